frame_sequencer: RTL and testbench

Sequences one image frame at a time through the `image_processor` datapath. The block accepts an RGB pixel stream on a valid/ready handshake and drives the processor's r/g/b and threshold inputs from registers. It tracks column/row position and time-aligns position tags with the processor's blur latency, so downstream logic knows when gray/negative/binary/blurred are valid and where each pixel sits in the frame. Top-level instances wrap `image_processor` with this block.

---
 rtl/frame_seq_pkg.sv | 27 ++
 rtl/tag_delay_line.sv | 40 ++++
 rtl/frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: FSM state encoding and the position tag
// that travels alongside each pixel through the processor latency.
package frame_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   typedef struct packed {
      logic valid;
      logic sof;
      logic eof;
      logic sol;
      logic eol;
   } pix_tag_t;

   localparam pix_tag_t TAG_NONE = '0;

   // A one-entry dimension still needs a 1-bit counter.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register of pixel tags; the last stage is the registered
// tag output. Flush clears every stage in one cycle.
module tag_delay_line
   import frame_seq_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_flush,
   input  pix_tag_t i_tag,
   output pix_tag_t o_tag
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         pix_tag_t w_d;
         pix_tag_t r_q;

         if (gi == 0) begin : g_head
            assign w_d = i_tag;
         end else begin : g_body
            assign w_d = g_stage[gi-1].r_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_q <= TAG_NONE;
            end else if (i_flush) begin
               r_q <= TAG_NONE;
            end else begin
               r_q <= w_d;
            end
         end
      end
   endgenerate

   assign o_tag = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/frame_sequencer.sv
// Feeds one frame of RGB pixels into the image processor and emits position
// tags aligned to the processor's output latency.
module frame_sequencer
   import frame_seq_pkg::*;
#(
   parameter int IMG_W    = 64,
   parameter int IMG_H    = 48,
   parameter int PIPE_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] threshold_cfg,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_r,
   input  logic [7:0] s_g,
   input  logic [7:0] s_b,
   output logic [7:0] proc_r,
   output logic [7:0] proc_g,
   output logic [7:0] proc_b,
   output logic [7:0] proc_threshold,
   output logic       out_valid,
   output logic       out_sof,
   output logic       out_eof,
   output logic       out_sol,
   output logic       out_eol,
   output logic       busy,
   output logic       done
);

   localparam int CW = cnt_w(IMG_W);
   localparam int RW = cnt_w(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   seq_state_t    r_state;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_s_ready;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_proc_r;
   logic [7:0]    r_proc_g;
   logic [7:0]    r_proc_b;
   logic [7:0]    r_proc_threshold;

   logic          w_hs;
   logic          w_last;
   logic          w_abort;
   pix_tag_t      w_push_tag;
   pix_tag_t      w_tag_out;

   // s_ready is only ever high in RUN, so it doubles as the RUN qualifier here.
   assign w_hs    = s_valid & r_s_ready;
   assign w_last  = (r_col == COL_LAST) && (r_row == ROW_LAST);
   assign w_abort = abort && ((r_state == RUN) || (r_state == DRAIN));

   always_comb begin
      w_push_tag = TAG_NONE;
      if (w_hs) begin
         w_push_tag.valid = 1'b1;
         w_push_tag.sof   = (r_col == '0) && (r_row == '0);
         w_push_tag.sol   = (r_col == '0);
         w_push_tag.eol   = (r_col == COL_LAST);
         w_push_tag.eof   = w_last;
      end
   end

   tag_delay_line #(
      .DEPTH (PIPE_LAT + 1)
   ) u_tag_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_abort),
      .i_tag   (w_push_tag),
      .o_tag   (w_tag_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_col            <= '0;
         r_row            <= '0;
         r_s_ready        <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_proc_r         <= '0;
         r_proc_g         <= '0;
         r_proc_b         <= '0;
         r_proc_threshold <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_proc_threshold <= threshold_cfg;
                  r_col            <= '0;
                  r_row            <= '0;
                  r_s_ready        <= 1'b1;
                  r_busy           <= 1'b1;
                  r_state          <= RUN;
               end
            end
            RUN: begin
               // Abort wins over a coincident handshake: the pixel is dropped.
               if (abort) begin
                  r_s_ready <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= IDLE;
               end else if (w_hs) begin
                  r_proc_r <= s_r;
                  r_proc_g <= s_g;
                  r_proc_b <= s_b;
                  if (w_last) begin
                     r_col     <= '0;
                     r_row     <= '0;
                     r_s_ready <= 1'b0;
                     r_state   <= DRAIN;
                  end else if (r_col == COL_LAST) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_tag_out.valid && w_tag_out.eof) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_s_ready <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign s_ready        = r_s_ready;
   assign busy           = r_busy;
   assign done           = r_done;
   assign proc_r         = r_proc_r;
   assign proc_g         = r_proc_g;
   assign proc_b         = r_proc_b;
   assign proc_threshold = r_proc_threshold;

   assign out_valid = w_tag_out.valid;
   assign out_sof   = w_tag_out.valid & w_tag_out.sof;
   assign out_eof   = w_tag_out.valid & w_tag_out.eof;
   assign out_sol   = w_tag_out.valid & w_tag_out.sol;
   assign out_eol   = w_tag_out.valid & w_tag_out.eol;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a 4x2 instance with two-cycle latency and
// a 4x1 zero-latency instance sharing the same stimulus.
module tb_frame_sequencer;

   localparam int LAT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] threshold_cfg = '0;
   logic       s_valid = 1'b0;
   logic [7:0] s_r = '0;
   logic [7:0] s_g = '0;
   logic [7:0] s_b = '0;

   logic       s_ready, out_valid, out_sof, out_eof, out_sol, out_eol, busy, done;
   logic [7:0] proc_r, proc_g, proc_b, proc_threshold;
   logic       m_s_ready, m_out_valid, m_out_sof, m_out_eof, m_out_sol, m_out_eol, m_busy, m_done;
   logic [7:0] m_proc_r, m_proc_g, m_proc_b, m_proc_threshold;

   int         n_vec = 0;
   int         n_err = 0;
   int         frame_id = 0;
   logic [7:0] exp_r = '0;
   logic [7:0] exp_g = '0;
   logic [7:0] exp_b = '0;
   logic [7:0] exp_thr = '0;

   always #5 clk = ~clk;

   frame_sequencer #(.IMG_W(4), .IMG_H(2), .PIPE_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .threshold_cfg(threshold_cfg), .s_valid(s_valid), .s_ready(s_ready),
      .s_r(s_r), .s_g(s_g), .s_b(s_b),
      .proc_r(proc_r), .proc_g(proc_g), .proc_b(proc_b), .proc_threshold(proc_threshold),
      .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
      .out_sol(out_sol), .out_eol(out_eol), .busy(busy), .done(done)
   );

   frame_sequencer #(.IMG_W(4), .IMG_H(1), .PIPE_LAT(0)) u_dut_min (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .threshold_cfg(threshold_cfg), .s_valid(s_valid), .s_ready(m_s_ready),
      .s_r(s_r), .s_g(s_g), .s_b(s_b),
      .proc_r(m_proc_r), .proc_g(m_proc_g), .proc_b(m_proc_b), .proc_threshold(m_proc_threshold),
      .out_valid(m_out_valid), .out_sof(m_out_sof), .out_eof(m_out_eof),
      .out_sol(m_out_sol), .out_eol(m_out_eol), .busy(m_busy), .done(m_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pix_r(input int j);
      return {4'(frame_id), 4'(j)};
   endfunction
   function automatic logic [7:0] pix_g(input int j);
      return ~pix_r(j);
   endfunction
   function automatic logic [7:0] pix_b(input int j);
      return pix_r(j) ^ 8'h5A;
   endfunction

   // Flags vector order: {valid, sof, sol, eol, eof, done, busy}
   task automatic run_frame(input string nm, input logic [7:0] thr, input logic [63:0] vpat,
                            input int start_edge, input int abort_pix);
      int h [8];
      int pix, last_e, j;
      bit rdy, hs, ab, ended;
      logic [6:0] ef;
      frame_id++;
      threshold_cfg = thr;
      start = 1'b1;
      abort = 1'b0;
      s_valid = 1'b0;
      tick();
      start = 1'b0;
      exp_thr = thr;
      chk({nm, " start s_ready"}, 32'(s_ready), 32'd1);
      chk({nm, " start busy"}, 32'(busy), 32'd1);
      chk({nm, " start threshold"}, 32'(proc_threshold), 32'(exp_thr));
      pix = 0;
      last_e = -1;
      rdy = 1'b1;
      ended = 1'b0;
      for (int e = 1; e <= 60; e++) begin
         s_valid = vpat[e-1] && (pix < 8);
         s_r = pix_r(pix);
         s_g = pix_g(pix);
         s_b = pix_b(pix);
         if (e == start_edge) begin
            start = 1'b1;
            threshold_cfg = 8'h10;
         end
         ab = (pix == abort_pix) && s_valid;
         abort = ab;
         hs = s_valid && rdy;
         tick();
         start = 1'b0;
         abort = 1'b0;
         if (ab) begin
            for (int c = 0; c < 5; c++) begin
               if (c > 0) begin
                  s_valid = 1'b0;
                  tick();
               end
               chk($sformatf("%s abort+%0d ready/busy/valid/done", nm, c),
                   32'({s_ready, busy, out_valid, done}), 32'd0);
               chk($sformatf("%s abort+%0d proc", nm, c),
                   32'({proc_r, proc_g, proc_b}), 32'({exp_r, exp_g, exp_b}));
            end
            ended = 1'b1;
            break;
         end
         if (hs) begin
            h[pix] = e;
            exp_r = pix_r(pix);
            exp_g = pix_g(pix);
            exp_b = pix_b(pix);
            pix++;
            if (pix == 8) begin
               rdy = 1'b0;
               last_e = e;
            end
         end
         j = -1;
         for (int k = 0; k < pix; k++) begin
            if (h[k] + LAT == e) j = k;
         end
         ef = '0;
         if (j >= 0) ef[6:2] = {1'b1, j == 0, (j % 4) == 0, (j % 4) == 3, j == 7};
         ef[1] = (last_e >= 0) && (e == last_e + LAT + 1);
         ef[0] = !((last_e >= 0) && (e >= last_e + LAT + 2));
         chk($sformatf("%s e%0d flags", nm, e),
             32'({out_valid, out_sof, out_sol, out_eol, out_eof, done, busy}), 32'(ef));
         chk($sformatf("%s e%0d s_ready", nm, e), 32'(s_ready), 32'(rdy));
         chk($sformatf("%s e%0d proc", nm, e),
             32'({proc_r, proc_g, proc_b}), 32'({exp_r, exp_g, exp_b}));
         chk($sformatf("%s e%0d threshold", nm, e), 32'(proc_threshold), 32'(exp_thr));
         if ((last_e >= 0) && (e == last_e + LAT + 2)) begin
            ended = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
      chk({nm, " finished in budget"}, 32'(ended), 32'd1);
      $display("frame %s: %0d pixels accepted, %0d vectors so far", nm, pix, n_vec);
   endtask

   function automatic logic [6:0] min_flags(input int e);
      case (e)
         1:       return 7'b1110001;
         2, 3:    return 7'b1000001;
         4:       return 7'b1001101;
         5:       return 7'b0000011;
         default: return 7'b0000000;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset data", 32'({proc_r, proc_g, proc_b, proc_threshold}), 32'd0);
      chk("reset flags", 32'({s_ready, out_valid, out_sof, out_eof, out_sol, out_eol, busy, done}), 32'd0);
      chk("reset min flags", 32'({m_s_ready, m_out_valid, m_busy, m_done, m_proc_threshold}), 32'd0);
      #3 rst_n = 1'b1;
      tick();

      run_frame("cont", 8'h80, '1, -1, -1);
      run_frame("bubble", 8'h80, ~64'h18, 5, -1);
      run_frame("abort", 8'hC4, '1, -1, 5);
      run_frame("clean", 8'h5C, '1, -1, -1);

      // Reset asserted asynchronously while the large instance is draining.
      frame_id++;
      threshold_cfg = 8'h33;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int j = 0; j < 8; j++) begin
         s_valid = 1'b1;
         s_r = pix_r(j);
         s_g = pix_g(j);
         s_b = pix_b(j);
         tick();
      end
      s_valid = 1'b0;
      tick();
      chk("rst drain ready/busy/valid", 32'({s_ready, busy, out_valid}), 32'b011);
      #2 rst_n = 1'b0;
      #1;
      chk("rst async data", 32'({proc_r, proc_g, proc_b, proc_threshold}), 32'd0);
      chk("rst async flags", 32'({s_ready, out_valid, out_sof, out_eof, out_sol, out_eol, busy, done}), 32'd0);
      #3 rst_n = 1'b1;
      tick();
      chk("rst idle flags", 32'({s_ready, busy, out_valid, done}), 32'd0);
      threshold_cfg = 8'h44;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rst restart", 32'({s_ready, busy, proc_threshold}), 32'({2'b11, 8'h44}));
      $display("frame reset: async reset in drain, %0d vectors so far", n_vec);

      // Return both instances to IDLE before the minimal-frame run.
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      tick();
      frame_id++;
      threshold_cfg = 8'h22;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("min threshold", 32'(m_proc_threshold), 32'h22);
      chk("min start s_ready", 32'(m_s_ready), 32'd1);
      for (int e = 1; e <= 6; e++) begin
         int pj;
         pj = (e <= 4) ? e - 1 : 3;
         s_valid = (e <= 4);
         s_r = pix_r(pj);
         s_g = pix_g(pj);
         s_b = pix_b(pj);
         tick();
         chk($sformatf("min e%0d flags", e),
             32'({m_out_valid, m_out_sof, m_out_sol, m_out_eol, m_out_eof, m_done, m_busy}),
             32'(min_flags(e)));
         chk($sformatf("min e%0d proc", e),
             32'({m_proc_r, m_proc_g, m_proc_b}), 32'({pix_r(pj), pix_g(pj), pix_b(pj)}));
         chk($sformatf("min e%0d s_ready", e), 32'(m_s_ready), 32'(e <= 3));
      end
      s_valid = 1'b0;
      $display("frame min: 4 pixels, %0d vectors so far", n_vec);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
